// File: rtl/avlnst_skid_slice_if.sv
// Avalon-ST packet interface: one beat of data with start/end-of-packet markers
// and a valid/ready handshake.
interface avalonST_pkt_iface #(
  parameter int unsigned DATA_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] if_data;
  logic                  if_vld;
  logic                  if_sof;
  logic                  if_eof;
  logic                  if_rdy;

  modport sink   (input  if_data, if_vld, if_sof, if_eof, output if_rdy);
  modport source (output if_data, if_vld, if_sof, if_eof, input  if_rdy);
endinterface

// File: rtl/avlnst_skid_slice.sv
// Fully registered Avalon-ST skid slice (output + skid beat registers).
// Define AVLNST_SKID_PKT_CHK_EN to add the sticky sof/eof framing checker (o_pkt_err).
module avlnst_skid_slice #(
  parameter int unsigned DATA_WIDTH = 1
) (
  input logic               i_clk,
  input logic               i_rst_n,
  avalonST_pkt_iface.sink   if_avlnst_snk,
  avalonST_pkt_iface.source if_avlnst_src
`ifdef AVLNST_SKID_PKT_CHK_EN
  ,
  output logic              o_pkt_err
`endif
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sof;
    logic                  eof;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_n;
  beat_t  out_q;
  beat_t  skid_q;
  beat_t  in_beat;
  logic   vld_q;
  logic   rdy_q;
  logic   up_xfer;
  logic   dn_xfer;
  logic   load_out;
  logic   load_skid;
  logic   out_from_skid;

  assign in_beat = '{data: if_avlnst_snk.if_data,
                     sof:  if_avlnst_snk.if_sof,
                     eof:  if_avlnst_snk.if_eof};

  assign up_xfer = if_avlnst_snk.if_vld & rdy_q;
  assign dn_xfer = vld_q & if_avlnst_src.if_rdy;

  // Next state and beat-register load controls.
  always_comb begin
    state_n       = state_q;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (up_xfer) begin
          state_n  = BUSY;
          load_out = 1'b1;
        end
      end
      BUSY: begin
        if (up_xfer && dn_xfer) begin
          load_out = 1'b1;
        end else if (up_xfer) begin
          state_n   = FULL;
          load_skid = 1'b1;
        end else if (dn_xfer) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (dn_xfer) begin
          state_n       = BUSY;
          load_out      = 1'b1;
          out_from_skid = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  // State, handshake flops and beat registers; vld/rdy are pre-decoded from state_n.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_n;
      vld_q   <= (state_n != EMPTY);
      rdy_q   <= (state_n != FULL);
      if (load_out) begin
        out_q <= out_from_skid ? skid_q : in_beat;
      end
      if (load_skid) begin
        skid_q <= in_beat;
      end
    end
  end

  assign if_avlnst_snk.if_rdy  = rdy_q;
  assign if_avlnst_src.if_vld  = vld_q;
  assign if_avlnst_src.if_data = out_q.data;
  assign if_avlnst_src.if_sof  = out_q.sof;
  assign if_avlnst_src.if_eof  = out_q.eof;

`ifdef AVLNST_SKID_PKT_CHK_EN
  logic in_pkt_q;
  logic err_q;

  // Framing check on accepted beats: sof inside a packet, or a non-sof beat outside one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_pkt_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (up_xfer) begin
      if ((in_beat.sof && in_pkt_q) || (!in_beat.sof && !in_pkt_q)) begin
        err_q <= 1'b1;
      end
      if (in_beat.eof) begin
        in_pkt_q <= 1'b0;
      end else if (in_beat.sof) begin
        in_pkt_q <= 1'b1;
      end
    end
  end

  assign o_pkt_err = err_q;
`endif

endmodule

// File: tb/tb_avlnst_skid_slice.sv
// Directed and scoreboarded bench for avlnst_skid_slice; framing-error checks
// are compiled in when AVLNST_SKID_PKT_CHK_EN is defined.
module tb_avlnst_skid_slice;
  localparam int unsigned DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  avalonST_pkt_iface #(.DATA_WIDTH(DW)) snk_if ();
  avalonST_pkt_iface #(.DATA_WIDTH(DW)) src_if ();

`ifdef AVLNST_SKID_PKT_CHK_EN
  logic pkt_err;
`endif

  avlnst_skid_slice #(.DATA_WIDTH(DW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .if_avlnst_snk (snk_if),
    .if_avlnst_src (src_if)
`ifdef AVLNST_SKID_PKT_CHK_EN
    ,
    .o_pkt_err     (pkt_err)
`endif
  );

  task automatic drive_beat(input logic vld, input logic [DW-1:0] d,
                            input logic sof, input logic eof);
    snk_if.if_vld  = vld;
    snk_if.if_data = d;
    snk_if.if_sof  = sof;
    snk_if.if_eof  = eof;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    drive_beat(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive_beat(1'b0, 8'h5A, 1'b1, 1'b1);
    src_if.if_rdy = 1'b1;
    #12;
    n_checks++;
    if ({src_if.if_vld, snk_if.if_rdy} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_handshake: vld/rdy=%b required 00", {src_if.if_vld, snk_if.if_rdy});
    end
    n_checks++;
    if ({src_if.if_data, src_if.if_sof, src_if.if_eof} !== 10'h000) begin
      n_errors++;
      $display("FAIL reset_beat: got %h required 000", {src_if.if_data, src_if.if_sof, src_if.if_eof});
    end
`ifdef AVLNST_SKID_PKT_CHK_EN
    n_checks++;
    if (pkt_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_err: got %b required 0", pkt_err);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive_beat(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (snk_if.if_rdy !== 1'b0) begin
      n_errors++;
      $display("FAIL release_rdy_before_edge: got %b required 0", snk_if.if_rdy);
    end
    tick();
    n_checks++;
    if ({src_if.if_vld, snk_if.if_rdy} !== 2'b01) begin
      n_errors++;
      $display("FAIL release_rdy_first_edge: vld/rdy=%b required 01", {src_if.if_vld, snk_if.if_rdy});
    end
  endtask

  task automatic test_stream;
    src_if.if_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive_beat(1'b1, 8'(i), (i == 1), (i == 8));
      tick();
      n_checks++;
      if ({src_if.if_vld, src_if.if_data, src_if.if_sof, src_if.if_eof} !==
          {1'b1, 8'(i), (i == 1), (i == 8)}) begin
        n_errors++;
        $display("FAIL stream_beat%0d: vld/data/sof/eof=%b/%h/%b/%b required 1/%h/%b/%b",
                 i, src_if.if_vld, src_if.if_data, src_if.if_sof, src_if.if_eof,
                 8'(i), (i == 1), (i == 8));
      end
      n_checks++;
      if (snk_if.if_rdy !== 1'b1) begin
        n_errors++;
        $display("FAIL stream_rdy%0d: got %b required 1", i, snk_if.if_rdy);
      end
    end
    drive_beat(1'b0, 8'hEE, 1'b0, 1'b0);
    tick();
    n_checks++;
    if ({src_if.if_vld, snk_if.if_rdy} !== 2'b01) begin
      n_errors++;
      $display("FAIL stream_drain: vld/rdy=%b required 01", {src_if.if_vld, snk_if.if_rdy});
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp_d   [10];
    logic       exp_vld [10];
    logic       exp_rdy [10];
    logic       src_rdy [10];
    int         nxt;
    logic       acc;
    exp_d   = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd0};
    exp_vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    src_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    nxt = 1;
    for (int k = 0; k < 10; k++) begin
      if (nxt <= 6) drive_beat(1'b1, 8'(nxt), (nxt == 1), (nxt == 6));
      else          drive_beat(1'b0, 8'hC3, 1'b1, 1'b1);
      src_if.if_rdy = src_rdy[k];
      acc = snk_if.if_vld & snk_if.if_rdy;
      tick();
      if (acc) nxt++;
      n_checks++;
      if (src_if.if_vld !== exp_vld[k] ||
          (exp_vld[k] && {src_if.if_data, src_if.if_sof, src_if.if_eof} !==
                         {exp_d[k], (exp_d[k] == 8'd1), (exp_d[k] == 8'd6)})) begin
        n_errors++;
        $display("FAIL bp_out_cyc%0d: vld/data=%b/%h required %b/%h",
                 k, src_if.if_vld, src_if.if_data, exp_vld[k], exp_d[k]);
      end
      n_checks++;
      if (snk_if.if_rdy !== exp_rdy[k]) begin
        n_errors++;
        $display("FAIL bp_rdy_cyc%0d: got %b required %b", k, snk_if.if_rdy, exp_rdy[k]);
      end
    end
  endtask

  task automatic test_random;
    logic [9:0]    sb [$];
    logic [9:0]    exp;
    logic [9:0]    obs;
    logic [DW-1:0] next_d;
    int            remain;
    logic          pending;
    logic          cur_sof;
    logic          cur_eof;
    logic [DW-1:0] cur_d;
    logic          up;
    logic          dn;
    next_d  = '0;
    remain  = 0;
    pending = 1'b0;
    cur_sof = 1'b0;
    cur_eof = 1'b0;
    cur_d   = '0;
    for (int c = 0; c < 1000; c++) begin
      if (!pending && ($urandom_range(0, 3) != 0)) begin
        cur_sof = (remain == 0);
        if (remain == 0) remain = int'($urandom_range(1, 16));
        cur_eof = (remain == 1);
        cur_d   = next_d;
        remain--;
        next_d  = next_d + 8'd1;
        pending = 1'b1;
      end
      if (pending) drive_beat(1'b1, cur_d, cur_sof, cur_eof);
      else         drive_beat(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
      src_if.if_rdy = ($urandom_range(0, 3) != 0);
      up  = snk_if.if_vld & snk_if.if_rdy;
      dn  = src_if.if_vld & src_if.if_rdy;
      obs = {src_if.if_data, src_if.if_sof, src_if.if_eof};
      tick();
      if (dn) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL rand_extra_beat: got %h required none", obs);
        end else begin
          exp = sb.pop_front();
          if (obs !== exp) begin
            n_errors++;
            $display("FAIL rand_order: got %h required %h", obs, exp);
          end
        end
      end
      if (up) begin
        sb.push_back({cur_d, cur_sof, cur_eof});
        pending = 1'b0;
      end
    end
    drive_beat(1'b0, 8'h00, 1'b0, 1'b0);
    src_if.if_rdy = 1'b1;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      dn  = src_if.if_vld & src_if.if_rdy;
      obs = {src_if.if_data, src_if.if_sof, src_if.if_eof};
      tick();
      if (dn) begin
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp) begin
          n_errors++;
          $display("FAIL rand_drain_order: got %h required %h", obs, exp);
        end
      end
    end
    tick();
    n_checks++;
    if (sb.size() != 0 || src_if.if_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL rand_scoreboard_empty: left %0d vld %b required 0 0", sb.size(), src_if.if_vld);
    end
`ifdef AVLNST_SKID_PKT_CHK_EN
    n_checks++;
    if (pkt_err !== 1'b0) begin
      n_errors++;
      $display("FAIL rand_no_err: got %b required 0", pkt_err);
    end
`endif
  endtask

  task automatic test_reset_full;
    src_if.if_rdy = 1'b0;
    drive_beat(1'b1, 8'hA1, 1'b1, 1'b0);
    tick();
    drive_beat(1'b1, 8'hA2, 1'b0, 1'b0);
    tick();
    drive_beat(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if ({src_if.if_vld, snk_if.if_rdy, src_if.if_data} !== {2'b10, 8'hA1}) begin
      n_errors++;
      $display("FAIL full_reached: vld/rdy/data=%b/%b/%h required 1/0/a1",
               src_if.if_vld, snk_if.if_rdy, src_if.if_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({src_if.if_vld, snk_if.if_rdy} !== 2'b00) begin
      n_errors++;
      $display("FAIL full_reset_async: vld/rdy=%b required 00", {src_if.if_vld, snk_if.if_rdy});
    end
    n_checks++;
    if (src_if.if_data !== 8'h00) begin
      n_errors++;
      $display("FAIL full_reset_data: got %h required 00", src_if.if_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    src_if.if_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({src_if.if_vld, snk_if.if_rdy} !== 2'b01) begin
        n_errors++;
        $display("FAIL full_reset_empty%0d: vld/rdy=%b required 01", k, {src_if.if_vld, snk_if.if_rdy});
      end
    end
  endtask

  task automatic test_pkt_err;
    logic [7:0] d    [4];
    logic       sof  [4];
    logic       eof  [4];
    logic       eerr [4];
    d    = '{8'h10, 8'h11, 8'h22, 8'h33};
    sof  = '{1'b1, 1'b1, 1'b0, 1'b1};
    eof  = '{1'b1, 1'b0, 1'b0, 1'b0};
    eerr = '{1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    src_if.if_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(1'b1, d[i], sof[i], eof[i]);
      tick();
      n_checks++;
      if ({src_if.if_vld, src_if.if_data, src_if.if_sof, src_if.if_eof} !==
          {1'b1, d[i], sof[i], eof[i]}) begin
        n_errors++;
        $display("FAIL err_seq_out%0d: data/sof/eof=%h/%b/%b required %h/%b/%b",
                 i, src_if.if_data, src_if.if_sof, src_if.if_eof, d[i], sof[i], eof[i]);
      end
`ifdef AVLNST_SKID_PKT_CHK_EN
      n_checks++;
      if (pkt_err !== eerr[i]) begin
        n_errors++;
        $display("FAIL err_flag%0d: got %b required %b", i, pkt_err, eerr[i]);
      end
`else
      if (eerr[i] === 1'bx) $display("unexpected x in error table");
`endif
    end
    drive_beat(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (src_if.if_vld !== 1'b0) begin
        n_errors++;
        $display("FAIL err_seq_idle%0d: vld got %b required 0", k, src_if.if_vld);
      end
`ifdef AVLNST_SKID_PKT_CHK_EN
      n_checks++;
      if (pkt_err !== 1'b1) begin
        n_errors++;
        $display("FAIL err_sticky%0d: got %b required 1", k, pkt_err);
      end
`endif
    end
  endtask

  initial begin
    drive_beat(1'b0, 8'h00, 1'b0, 1'b0);
    src_if.if_rdy = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_full();
    test_pkt_err();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
